// File: rtl/pc_gen_pkg.sv
// Shared constants, state encoding and types for the fetch-address generator.
package pc_gen_pkg;

    localparam int unsigned PC_XLEN       = 64;
    localparam logic [63:0] PC_RESET_ADDR = 64'h0000_0000_8000_0000;

    localparam logic STATE_BOOT_ENC = 1'b0;
    localparam logic STATE_RUN_ENC  = 1'b1;

    typedef enum logic {
        BOOT = STATE_BOOT_ENC,
        RUN  = STATE_RUN_ENC
    } pc_state_e;

endpackage

// File: rtl/pc_redir_arb.sv
// Fixed-priority redirect arbiter: flush beats every source, lower index beats higher.
module pc_redir_arb
    import pc_gen_pkg::*;
#(
    parameter int unsigned     XLEN       = PC_XLEN,
    parameter int unsigned     NUM_REDIR  = 2,
    parameter int unsigned     INST_BYTES = 4,
    parameter logic [XLEN-1:0] RESET_ADDR = XLEN'(PC_RESET_ADDR)
)(
    input  logic                      flush,
    input  logic [NUM_REDIR-1:0]      redir_valid,
    input  logic [NUM_REDIR*XLEN-1:0] redir_pc,
    output logic                      redir_event,
    output logic [XLEN-1:0]           redir_target
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INST_BYTES - 1);

    logic [XLEN-1:0] src_pc;
    logic            found;

    always_comb begin
        src_pc = '0;
        found  = 1'b0;
        for (int unsigned k = 0; k < NUM_REDIR; k++) begin
            if (redir_valid[k] && !found) begin
                src_pc = redir_pc[k*XLEN +: XLEN];
                found  = 1'b1;
            end
        end
        redir_event  = flush | (|redir_valid);
        redir_target = flush ? RESET_ADDR : (src_pc & ALIGN_MASK);
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-address generator: issues epoch-tagged fetch requests over valid/ready,
// parks redirects that arrive while a request is held, and caps in-flight fetches.
//
// state | meaning
// BOOT  | first cycle after reset; no request may be raised
// RUN   | normal issue
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned     XLEN            = PC_XLEN,
    parameter logic [XLEN-1:0] RESET_ADDR      = XLEN'(PC_RESET_ADDR),
    parameter int unsigned     NUM_REDIR       = 2,
    parameter int unsigned     INST_BYTES      = 4,
    parameter int unsigned     EPOCH_W         = 2,
    parameter int unsigned     MAX_OUTSTANDING = 2,
    localparam int unsigned    CNT_W           = $clog2(MAX_OUTSTANDING + 1)
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      stall_i,
    input  logic                      flush_i,
    input  logic [NUM_REDIR-1:0]      redir_valid_i,
    input  logic [NUM_REDIR*XLEN-1:0] redir_pc_i,
    output logic                      req_valid_o,
    input  logic                      req_ready_i,
    output logic [XLEN-1:0]           req_pc_o,
    output logic [EPOCH_W-1:0]        req_epoch_o,
    input  logic                      resp_valid_i,
    output logic [EPOCH_W-1:0]        epoch_o,
    output logic [CNT_W-1:0]          inflight_o
);

    pc_state_e        state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             req_valid_q, req_valid_d;
    logic [EPOCH_W-1:0] req_epoch_q, req_epoch_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_valid_q, pend_valid_d;
    logic [XLEN-1:0]  pend_pc_q, pend_pc_d;

    logic             redir_event;
    logic [XLEN-1:0]  redir_target;
    logic             hold;
    logic             fire;
    logic             resp_dec;
    logic             load;

    pc_redir_arb #(
        .XLEN       (XLEN),
        .NUM_REDIR  (NUM_REDIR),
        .INST_BYTES (INST_BYTES),
        .RESET_ADDR (RESET_ADDR)
    ) u_arb (
        .flush        (flush_i),
        .redir_valid  (redir_valid_i),
        .redir_pc     (redir_pc_i),
        .redir_event  (redir_event),
        .redir_target (redir_target)
    );

    always_comb begin
        hold     = req_valid_q & ~req_ready_i;
        fire     = req_valid_q & req_ready_i;
        state_d  = RUN;
        epoch_d  = epoch_q + EPOCH_W'(redir_event);

        pc_d         = pc_q;
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;

        // pc_q doubles as the address of the outstanding request, so it may only
        // move when nothing is being held on the interface.
        if (redir_event) begin
            if (hold) begin
                pend_valid_d = 1'b1;
                pend_pc_d    = redir_target;
            end else begin
                pc_d         = redir_target;
                pend_valid_d = 1'b0;
            end
        end else if (pend_valid_q && !hold) begin
            pc_d         = pend_pc_q;
            pend_valid_d = 1'b0;
        end else if (fire) begin
            pc_d = pc_q + XLEN'(INST_BYTES);
        end

        resp_dec = resp_valid_i & (cnt_q != '0);
        cnt_d    = cnt_q + CNT_W'(fire) - CNT_W'(resp_dec);

        req_valid_d = hold
                    | ((state_q == RUN) & ~stall_i & ~pend_valid_d
                       & (cnt_d < CNT_W'(MAX_OUTSTANDING)));

        load        = req_valid_d & ~hold;
        req_epoch_d = load ? epoch_d : req_epoch_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= BOOT;
            pc_q         <= RESET_ADDR;
            req_valid_q  <= 1'b0;
            req_epoch_q  <= '0;
            epoch_q      <= '0;
            cnt_q        <= '0;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= RESET_ADDR;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_valid_q  <= req_valid_d;
            req_epoch_q  <= req_epoch_d;
            epoch_q      <= epoch_d;
            cnt_q        <= cnt_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
        end
    end

    assign req_valid_o = req_valid_q;
    assign req_pc_o    = pc_q;
    assign req_epoch_o = req_epoch_q;
    assign epoch_o     = epoch_q;
    assign inflight_o  = cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: per-cycle vector table plus a fire scoreboard.
module tb_pc_gen;

    localparam int XLEN = 64;
    localparam int NV   = 21;

    logic              clk;
    logic              rst_n;
    logic              stall_i;
    logic              flush_i;
    logic [1:0]        redir_valid_i;
    logic [2*XLEN-1:0] redir_pc_i;
    logic              req_valid_o;
    logic              req_ready_i;
    logic [XLEN-1:0]   req_pc_o;
    logic [1:0]        req_epoch_o;
    logic              resp_valid_i;
    logic [1:0]        epoch_o;
    logic [1:0]        inflight_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        stall;
        logic        flush;
        logic [1:0]  rv;
        logic [63:0] rpc0;
        logic [63:0] rpc1;
        logic        ready;
        logic        resp;
        logic        exp_valid;
        logic [63:0] exp_pc;
        logic [1:0]  exp_repoch;
        logic [1:0]  exp_epoch;
        logic [1:0]  exp_inf;
    } vec_t;

    typedef struct {
        logic [63:0] pc;
        logic [1:0]  ep;
    } sb_t;

    vec_t vecs[NV];
    sb_t  sbq[$];

    pc_gen dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .redir_valid_i (redir_valid_i),
        .redir_pc_i    (redir_pc_i),
        .req_valid_o   (req_valid_o),
        .req_ready_i   (req_ready_i),
        .req_pc_o      (req_pc_o),
        .req_epoch_o   (req_epoch_o),
        .resp_valid_i  (resp_valid_i),
        .epoch_o       (epoch_o),
        .inflight_o    (inflight_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic fl, input logic [1:0] rv,
                                input logic [63:0] p0, input logic [63:0] p1,
                                input logic rdy, input logic rsp,
                                input logic ev, input logic [63:0] epc,
                                input logic [1:0] erep, input logic [1:0] eep,
                                input logic [1:0] einf);
        vec_t v;
        v.stall = st; v.flush = fl; v.rv = rv; v.rpc0 = p0; v.rpc1 = p1;
        v.ready = rdy; v.resp = rsp; v.exp_valid = ev; v.exp_pc = epc;
        v.exp_repoch = erep; v.exp_epoch = eep; v.exp_inf = einf;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall_i = 1'b0; flush_i = 1'b0; redir_valid_i = '0; redir_pc_i = '0;
        resp_valid_i = 1'b0;
    endtask

    task automatic chk_outs(input string tag, input logic v, input logic [63:0] pc,
                            input logic [1:0] rep, input logic [1:0] ep, input logic [1:0] inf);
        chk({tag, " valid"},    64'(req_valid_o), 64'(v));
        chk({tag, " pc"},       req_pc_o,         pc);
        chk({tag, " req_epoch"}, 64'(req_epoch_o), 64'(rep));
        chk({tag, " epoch"},    64'(epoch_o),     64'(ep));
        chk({tag, " inflight"}, 64'(inflight_o),  64'(inf));
    endtask

    // Every accepted request must match the oldest expected fetch.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && req_valid_o && req_ready_i) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb unexpected fire: got pc %0h, expected none", req_pc_o);
                end else begin
                    sb_t e;
                    e = sbq.pop_front();
                    chk("sb fire pc", req_pc_o, e.pc);
                    chk("sb fire epoch", 64'(req_epoch_o), 64'(e.ep));
                end
            end
        end
    end

    initial begin
        //                 st fl rv     rpc0        rpc1        rdy rsp  v  pc            rep ep inf
        vecs[0]  = mk(0, 0, 2'b00, 64'h0,    64'h0,    1, 0,  0, 64'h80000000, 0, 0, 0);
        vecs[1]  = mk(0, 0, 2'b00, 64'h0,    64'h0,    1, 1,  1, 64'h80000000, 0, 0, 0);
        vecs[2]  = mk(0, 0, 2'b00, 64'h0,    64'h0,    1, 1,  1, 64'h80000004, 0, 0, 1);
        vecs[3]  = mk(0, 0, 2'b00, 64'h0,    64'h0,    1, 1,  1, 64'h80000008, 0, 0, 1);
        vecs[4]  = mk(0, 0, 2'b11, 64'h1000, 64'h2000, 1, 1,  1, 64'h1000,     1, 1, 1);
        vecs[5]  = mk(0, 1, 2'b11, 64'h1000, 64'h2000, 1, 1,  1, 64'h80000000, 2, 2, 1);
        vecs[6]  = mk(0, 0, 2'b00, 64'h0,    64'h0,    0, 1,  1, 64'h80000000, 2, 2, 0);
        vecs[7]  = mk(0, 0, 2'b10, 64'h0,    64'h3002, 0, 0,  1, 64'h80000000, 2, 3, 0);
        vecs[8]  = mk(1, 0, 2'b00, 64'h0,    64'h0,    0, 0,  1, 64'h80000000, 2, 3, 0);
        vecs[9]  = mk(0, 0, 2'b00, 64'h0,    64'h0,    1, 0,  1, 64'h3000,     3, 3, 1);
        vecs[10] = mk(0, 0, 2'b00, 64'h0,    64'h0,    1, 0,  0, 64'h3004,     3, 3, 2);
        vecs[11] = mk(0, 0, 2'b00, 64'h0,    64'h0,    1, 0,  0, 64'h3004,     3, 3, 2);
        vecs[12] = mk(0, 0, 2'b00, 64'h0,    64'h0,    1, 1,  1, 64'h3004,     3, 3, 1);
        vecs[13] = mk(1, 0, 2'b00, 64'h0,    64'h0,    1, 0,  0, 64'h3008,     3, 3, 2);
        vecs[14] = mk(1, 0, 2'b00, 64'h0,    64'h0,    1, 1,  0, 64'h3008,     3, 3, 1);
        vecs[15] = mk(0, 0, 2'b00, 64'h0,    64'h0,    1, 1,  1, 64'h3008,     3, 3, 0);
        vecs[16] = mk(1, 0, 2'b01, 64'h4000, 64'h0,    0, 0,  1, 64'h3008,     3, 0, 0);
        vecs[17] = mk(1, 0, 2'b00, 64'h0,    64'h0,    1, 0,  0, 64'h4000,     3, 0, 1);
        vecs[18] = mk(0, 0, 2'b00, 64'h0,    64'h0,    1, 0,  1, 64'h4000,     0, 0, 1);
        vecs[19] = mk(0, 0, 2'b01, 64'h5003, 64'h0,    1, 1,  1, 64'h5000,     1, 1, 1);
        vecs[20] = mk(0, 0, 2'b00, 64'h0,    64'h0,    0, 1,  1, 64'h5000,     1, 1, 0);

        rst_n = 1'b0;
        req_ready_i = 1'b1;
        idle_inputs();
        step();
        step();
        chk_outs("reset", 1'b0, 64'h80000000, 2'd0, 2'd0, 2'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            stall_i       = vecs[i].stall;
            flush_i       = vecs[i].flush;
            redir_valid_i = vecs[i].rv;
            redir_pc_i    = {vecs[i].rpc1, vecs[i].rpc0};
            req_ready_i   = vecs[i].ready;
            resp_valid_i  = vecs[i].resp;
            if (i > 0 && vecs[i].ready && vecs[i-1].exp_valid) begin
                sb_t e;
                e.pc = vecs[i-1].exp_pc;
                e.ep = vecs[i-1].exp_repoch;
                sbq.push_back(e);
            end
            step();
            chk_outs($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_pc,
                     vecs[i].exp_repoch, vecs[i].exp_epoch, vecs[i].exp_inf);
        end
        chk("sb drained after table", 64'(sbq.size()), 64'd0);

        // Asynchronous reset mid-operation: outputs drop without a clock edge.
        idle_inputs();
        req_ready_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_outs("async_rst", 1'b0, 64'h80000000, 2'd0, 2'd0, 2'd0);
        step();
        rst_n = 1'b1;

        // Epoch wrap: four redirects while the first request is held.
        step();
        chk_outs("wrap boot", 1'b0, 64'h80000000, 2'd0, 2'd0, 2'd0);
        step();
        chk_outs("wrap first", 1'b1, 64'h80000000, 2'd0, 2'd0, 2'd0);
        for (int k = 1; k <= 4; k++) begin
            redir_valid_i = 2'b01;
            redir_pc_i    = {64'h0, 64'(k * 256)};
            step();
            chk($sformatf("wrap epoch %0d", k), 64'(epoch_o), 64'(k % 4));
            chk($sformatf("wrap held pc %0d", k), req_pc_o, 64'h80000000);
            chk($sformatf("wrap held epoch %0d", k), 64'(req_epoch_o), 64'd0);
        end
        idle_inputs();
        req_ready_i = 1'b1;
        begin
            sb_t e;
            e.pc = 64'h80000000;
            e.ep = 2'd0;
            sbq.push_back(e);
        end
        step();
        req_ready_i = 1'b0;
        chk_outs("wrap applied", 1'b1, 64'h400, 2'd0, 2'd0, 2'd1);
        step();
        chk("sb drained at end", 64'(sbq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
